// File: rtl/keypad_entry_display.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_display
// Description : Scanned, debounced key matrix feeding an editable decimal entry
//               buffer, shown live on a multiplexed 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_display #(
    parameter int   NUM           = 8,
    parameter logic VALID_SIGNAL  = 1'b0,
    parameter int   ROW_NUM       = 4,
    parameter int   COL_NUM       = 4,
    parameter int   DELAY_TIME    = 200,
    parameter int   DEBOUNCE_TIME = 2000,
    parameter int   CLK_CYCLE     = 5000,
    parameter int   BLINK_CYCLES  = 2500000
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [COL_NUM-1:0]         col,
    output logic [ROW_NUM-1:0]         row,
    output logic [7:0]                 led_display_seg,
    output logic [NUM-1:0]             led_display_sel,
    output logic [4*NUM-1:0]           value,
    output logic                       value_valid,
    output logic [$clog2(NUM+1)-1:0]   digit_count,
    output logic                       entry_err
);

    localparam int c_KEY_NUM = ROW_NUM * COL_NUM;
    localparam int c_KEY_W   = $clog2(c_KEY_NUM);
    localparam int c_ROW_W   = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int c_DLY_W   = $clog2(DELAY_TIME);
    localparam int c_DEB_W   = $clog2(DEBOUNCE_TIME + 1);
    localparam int c_DIG_W   = $clog2(NUM);
    localparam int c_CNT_W   = $clog2(NUM + 1);
    localparam int c_DCY_W   = (CLK_CYCLE > 1) ? $clog2(CLK_CYCLE) : 1;
    localparam int c_BLK_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [c_KEY_W-1:0] c_KEY_BKSP  = c_KEY_W'(10);
    localparam logic [c_KEY_W-1:0] c_KEY_CLR   = c_KEY_W'(11);
    localparam logic [c_KEY_W-1:0] c_KEY_ENTER = c_KEY_W'(12);

    function automatic logic [6:0] f_hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Row scanner
    // ------------------------------------------------------------------
    logic                  r_scan_on;
    logic [c_ROW_W-1:0]    r_row_idx;
    logic [c_DLY_W-1:0]    r_dly;
    logic [c_KEY_NUM-1:0]  r_sweep;
    logic [c_KEY_NUM-1:0]  r_raw_vec;
    logic [c_KEY_NUM-1:0]  w_sweep;
    logic [c_ROW_W-1:0]    w_row_idx_nxt;
    logic                  w_row_last;
    logic                  w_row_wrap;
    logic                  w_raw_load;

    always_comb begin
        w_sweep = r_sweep;
        w_sweep[int'(r_row_idx)*COL_NUM +: COL_NUM] = ~col;
    end

    assign w_row_last    = (r_dly == c_DLY_W'(DELAY_TIME - 1));
    assign w_row_wrap    = (r_row_idx == c_ROW_W'(ROW_NUM - 1));
    assign w_row_idx_nxt = w_row_wrap ? '0 : r_row_idx + c_ROW_W'(1);
    assign w_raw_load    = r_scan_on & w_row_last & w_row_wrap;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scan_on <= 1'b0;
            r_row_idx <= '0;
            r_dly     <= '0;
            r_sweep   <= '0;
            r_raw_vec <= '0;
            row       <= '1;
        end else if (!r_scan_on) begin
            r_scan_on <= 1'b1;
            row       <= ~ROW_NUM'(1);
        end else if (w_row_last) begin
            r_dly     <= '0;
            r_sweep   <= w_sweep;
            r_row_idx <= w_row_idx_nxt;
            row       <= ~(ROW_NUM'(1) << w_row_idx_nxt);
            if (w_row_wrap) begin
                r_raw_vec <= w_sweep;
            end
        end else begin
            r_dly <= r_dly + c_DLY_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Debounce and press-event extraction
    // ------------------------------------------------------------------
    logic [c_DEB_W-1:0]    r_deb_cnt;
    logic [c_KEY_NUM-1:0]  r_deb_vec;
    logic                  r_evt;
    logic [c_KEY_W-1:0]    r_evt_key;
    logic [c_KEY_NUM-1:0]  w_new;
    logic [c_KEY_W-1:0]    w_new_key;

    assign w_new = r_raw_vec & ~r_deb_vec;

    // Lowest-indexed newly pressed key wins; scanning downward lets it overwrite.
    always_comb begin
        w_new_key = '0;
        for (int i = c_KEY_NUM - 1; i >= 0; i--) begin
            if (w_new[i]) begin
                w_new_key = c_KEY_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_deb_cnt <= '0;
            r_deb_vec <= '0;
            r_evt     <= 1'b0;
            r_evt_key <= '0;
        end else begin
            r_evt <= 1'b0;
            if (w_raw_load && (w_sweep != r_raw_vec)) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt != c_DEB_W'(DEBOUNCE_TIME)) begin
                r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
                if (r_deb_cnt == c_DEB_W'(DEBOUNCE_TIME - 1)) begin
                    r_deb_vec <= r_raw_vec;
                    r_evt     <= |w_new;
                    r_evt_key <= w_new_key;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry buffer editing
    // ------------------------------------------------------------------
    logic [4*NUM-1:0] r_buf;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (digit_count == c_CNT_W'(NUM));
    assign w_empty = (digit_count == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf       <= '0;
            digit_count <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            entry_err   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            entry_err   <= 1'b0;
            if (r_evt) begin
                if (r_evt_key < c_KEY_BKSP) begin
                    if (w_full) begin
                        entry_err <= 1'b1;
                    end else begin
                        r_buf       <= {r_buf[4*NUM-5:0], r_evt_key[3:0]};
                        digit_count <= digit_count + c_CNT_W'(1);
                    end
                end else if (r_evt_key == c_KEY_BKSP) begin
                    if (w_empty) begin
                        entry_err <= 1'b1;
                    end else begin
                        r_buf       <= {4'h0, r_buf[4*NUM-1:4]};
                        digit_count <= digit_count - c_CNT_W'(1);
                    end
                end else if (r_evt_key == c_KEY_CLR) begin
                    r_buf       <= '0;
                    digit_count <= '0;
                end else if (r_evt_key == c_KEY_ENTER) begin
                    // Unused upper digits are already zero, so the buffer is the padded value.
                    value       <= r_buf;
                    value_valid <= 1'b1;
                    r_buf       <= '0;
                    digit_count <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display multiplexer and cursor blink
    // ------------------------------------------------------------------
    logic [c_DCY_W-1:0] r_dcyc;
    logic [c_DIG_W-1:0] r_dig_idx;
    logic [c_BLK_W-1:0] r_blk_cnt;
    logic               r_blink;
    logic [3:0]         w_nib;
    logic [7:0]         w_seg_raw;
    logic [NUM-1:0]     w_sel_raw;

    assign w_nib     = r_buf[int'(r_dig_idx)*4 +: 4];
    assign w_sel_raw = NUM'(1) << r_dig_idx;

    always_comb begin
        w_seg_raw = '0;
        if (c_CNT_W'(r_dig_idx) < digit_count) begin
            w_seg_raw[6:0] = f_hex7(w_nib);
        end else if ((r_dig_idx == '0) && w_empty) begin
            w_seg_raw[6:0] = f_hex7(4'h0);
        end
        if ((r_dig_idx == '0) && !w_full) begin
            w_seg_raw[7] = r_blink;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dcyc          <= '0;
            r_dig_idx       <= '0;
            r_blk_cnt       <= '0;
            r_blink         <= 1'b0;
            led_display_seg <= {8{~VALID_SIGNAL}};
            led_display_sel <= {NUM{~VALID_SIGNAL}};
        end else begin
            led_display_seg <= VALID_SIGNAL ? w_seg_raw : ~w_seg_raw;
            led_display_sel <= VALID_SIGNAL ? w_sel_raw : ~w_sel_raw;
            if (r_dcyc == c_DCY_W'(CLK_CYCLE - 1)) begin
                r_dcyc    <= '0;
                r_dig_idx <= (r_dig_idx == c_DIG_W'(NUM - 1)) ? '0 : r_dig_idx + c_DIG_W'(1);
            end else begin
                r_dcyc <= r_dcyc + c_DCY_W'(1);
            end
            if (r_blk_cnt == c_BLK_W'(BLINK_CYCLES - 1)) begin
                r_blk_cnt <= '0;
                r_blink   <= ~r_blink;
            end else begin
                r_blk_cnt <= r_blk_cnt + c_BLK_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_display.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_keypad_entry_display
// Description : Scoreboard bench for keypad_entry_display with a key-matrix model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_display;

    localparam int NUM = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic [15:0] value;
    logic        value_valid;
    logic [2:0]  digit_count;
    logic        entry_err;
    logic [15:0] keys = 16'h0;

    always #5 clk = ~clk;

    keypad_entry_display #(
        .NUM(NUM), .VALID_SIGNAL(1'b1), .ROW_NUM(4), .COL_NUM(4), .DELAY_TIME(4),
        .DEBOUNCE_TIME(40), .CLK_CYCLE(8), .BLINK_CYCLES(64)
    ) dut (
        .clk(clk), .rstn(rstn), .col(col), .row(row),
        .led_display_seg(seg), .led_display_sel(sel),
        .value(value), .value_valid(value_valid),
        .digit_count(digit_count), .entry_err(entry_err)
    );

    // Pulled-up columns; a closed key shorts its column to a row driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        int          cnt;
        bit          err;
        bit          vv;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    logic [15:0] m_buf = 16'h0;
    logic [15:0] m_value = 16'h0;
    int          m_cnt = 0;

    task automatic push_exp(input bit e, input bit v);
        exp_t x;
        x.cnt = m_cnt; x.err = e; x.vv = v; x.val = m_value;
        sb.push_back(x);
    endtask

    task automatic model_key(input int k);
        logic [3:0] d;
        d = 4'(k);
        if (k < 10) begin
            if (m_cnt < NUM) begin m_buf = {m_buf[11:0], d}; m_cnt++; push_exp(0, 0); end
            else push_exp(1, 0);
        end else if (k == 10) begin
            if (m_cnt > 0) begin m_buf = {4'h0, m_buf[15:4]}; m_cnt--; push_exp(0, 0); end
            else push_exp(1, 0);
        end else if (k == 11) begin
            m_buf = 16'h0;
            if (m_cnt != 0) begin m_cnt = 0; push_exp(0, 0); end
        end else if (k == 12) begin
            m_value = m_buf; m_buf = 16'h0; m_cnt = 0; push_exp(0, 1);
        end
    endtask

    // Any observable edit result is popped against the oldest expectation.
    int prev_cnt = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_cnt = 0;
        end else if (value_valid || entry_err || int'(digit_count) != prev_cnt) begin
            check_val("sb_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                check_val("sb_count", digit_count, x.cnt);
                check_val("sb_err", entry_err, x.err);
                check_val("sb_valid", value_valid, x.vv);
                check_val("sb_value", value, x.val);
            end
            prev_cnt = int'(digit_count);
        end
    end

    task automatic press(input logic [15:0] mask, input bit bounce);
        if (bounce) begin
            repeat (10) begin
                @(posedge clk);
                keys = ($urandom_range(0, 1) != 0) ? mask : 16'h0;
            end
        end
        @(posedge clk); keys = mask;
        repeat (150) @(posedge clk);
        keys = 16'h0;
        repeat (150) @(posedge clk);
    endtask

    task automatic key(input int k);
        model_key(k);
        press(16'h1 << k, 1'b1);
    endtask

    task automatic check_display();
        @(negedge clk);
        for (int i = 0; i < NUM; i++) begin
            int n;
            logic [6:0] e;
            n = 0;
            while (sel !== (4'b1 << i) && n < 64) begin @(negedge clk); n++; end
            check_val("disp_sel_found", n < 64, 1);
            if (i < m_cnt) e = seg_tbl[m_buf[4*i +: 4]];
            else if (i == 0) e = seg_tbl[0];
            else e = 7'h0;
            check_val($sformatf("disp_seg%0d", i), seg[6:0], e);
        end
    endtask

    task automatic dp_stats(output int ones, output int zeros);
        ones = 0; zeros = 0;
        repeat (200) begin
            @(negedge clk);
            if (sel == 4'b0001) begin
                if (seg[7]) ones++; else zeros++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_row"}, row, 4'hF);
        check_val({tag, "_seg"}, seg, 8'h00);
        check_val({tag, "_sel"}, sel, 4'h0);
        check_val({tag, "_value"}, value, 16'h0);
        check_val({tag, "_valid"}, value_valid, 0);
        check_val({tag, "_count"}, digit_count, 0);
        check_val({tag, "_err"}, entry_err, 0);
    endtask

    initial begin
        int ones, zeros, n;
        logic [3:0] prev_sel;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn = 1'b1;
        @(posedge clk); #1;
        check_val("row_after_rst", row, 4'b1110);
        check_val("sel_first", sel, 4'b0001);
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            prev_sel = sel;
            n = 0;
            while (sel == prev_sel && n < 100) begin @(negedge clk); n++; end
            check_val("sel_walk", sel, 4'b1 << (i % 4));
            check_val("sel_period", n, 8);
        end
        check_display();
        dp_stats(ones, zeros);
        check_val("dp_blinks", (ones > 0) && (zeros > 0), 1);

        key(1); key(2); key(3);
        check_display();
        key(4); key(5);
        check_display();
        dp_stats(ones, zeros);
        check_val("dp_off_full", ones, 0);

        key(11); key(1); key(2); key(10);
        check_display();
        key(10); key(10);
        check_display();

        key(9); key(0); key(7); key(12);
        check_val("enter_value", value, 16'h0907);
        check_val("enter_count", digit_count, 0);

        model_key(1);
        press(16'h0006, 1'b0);
        check_display();

        @(posedge clk); keys = 16'h0020;
        repeat (30) @(posedge clk);
        @(negedge clk); rstn = 1'b0; #1;
        check_reset_outputs("midrst");
        m_buf = 16'h0; m_cnt = 0; m_value = 16'h0; sb.delete();
        keys = 16'h0;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (200) @(posedge clk);
        check_val("post_rst_count", digit_count, 0);
        check_display();

        check_val("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
